// File: rtl/vga_frame_ctrl_if.sv
// vga_frame_ctrl_if: control/status bundle between the game logic, the VGA driver and vga_frame_ctrl
// Signals (named from the controller's point of view):
//   en_i        run request from game FSM
//   pause_i     suppress update requests while high
//   v_sync_i    driver field sync, active low
//   disp_i      driver active-display flag
//   upd_done_i  update logic finished (pulse or level)
//   vga_en_o    enable to VGA driver
//   frame_tick_o one-cycle pulse at vblank entry
//   upd_req_o   update window open (level)
//   swap_o      one-cycle frame-buffer swap pulse
//   overrun_o   sticky, update missed its window
//   frame_cnt_o count of vblank entries, wraps
// Modports: slave = controller side, master = surrounding system side.
interface vga_frame_ctrl_if #(
   parameter int FRAME_CNT_W = 16
);
   logic                   en_i;
   logic                   pause_i;
   logic                   v_sync_i;
   logic                   disp_i;
   logic                   upd_done_i;
   logic                   vga_en_o;
   logic                   frame_tick_o;
   logic                   upd_req_o;
   logic                   swap_o;
   logic                   overrun_o;
   logic [FRAME_CNT_W-1:0] frame_cnt_o;
   modport slave (
      input  en_i, pause_i, v_sync_i, disp_i, upd_done_i,
      output vga_en_o, frame_tick_o, upd_req_o, swap_o, overrun_o, frame_cnt_o
   );
   modport master (
      output en_i, pause_i, v_sync_i, disp_i, upd_done_i,
      input  vga_en_o, frame_tick_o, upd_req_o, swap_o, overrun_o, frame_cnt_o
   );
endinterface

// File: rtl/vga_frame_ctrl.sv
// vga_frame_ctrl: frame-level sequencer that enables the VGA driver, opens a game-update window in vblank and times the buffer swap
// Ports:
//   clk  pixel clock shared with the VGA driver
//   rst  asynchronous active-high reset
//   bus  vga_frame_ctrl_if.slave (en_i, pause_i, v_sync_i, disp_i, upd_done_i in;
//        vga_en_o, frame_tick_o, upd_req_o, swap_o, overrun_o, frame_cnt_o out, all registered)
// Optional feature: define VGA_OVERRUN_RETRY_EN to keep a late update request alive through
// the active display instead of dropping it; the default build drops it.
module vga_frame_ctrl #(
   parameter int V_DISP_LINES = 480,
   parameter int LINE_W       = 10,
   parameter int FRAME_CNT_W  = 16
) (
   input logic             clk,
   input logic             rst,
   vga_frame_ctrl_if.slave bus
);
   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACTIVE = 2'd1;
   localparam logic [1:0] S_UPDATE = 2'd2;
   localparam logic [1:0] S_READY  = 2'd3;
   localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(V_DISP_LINES - 1);
   logic [1:0]             state_q, state_d;
   logic [LINE_W-1:0]      line_q, line_d;
   logic [FRAME_CNT_W-1:0] frame_q, frame_d;
   logic                   disp_q, vs_q;
   logic                   vga_en_q, vga_en_d;
   logic                   tick_q, tick_d;
   logic                   req_q, req_d;
   logic                   swap_q, swap_d;
   logic                   ovr_q, ovr_d;
   logic                   disp_fall, disp_rise, vs_fall, count_en, vblank;
   // edges compare the live input against last cycle's sample
   assign disp_fall = disp_q & ~bus.disp_i;
   assign disp_rise = ~disp_q & bus.disp_i;
   assign vs_fall   = vs_q & ~bus.v_sync_i;
`ifdef VGA_OVERRUN_RETRY_EN
   // a retried update keeps the window open into the active region, so lines keep counting
   assign count_en = state_q != S_IDLE;
`else
   assign count_en = state_q == S_ACTIVE;
`endif
   // falling edge of the last visible line marks vblank entry
   assign vblank = count_en & disp_fall & (line_q == LAST_LINE);
   always_comb begin
      state_d  = state_q;
      line_d   = line_q;
      frame_d  = frame_q;
      vga_en_d = vga_en_q;
      tick_d   = 1'b0;
      req_d    = req_q;
      swap_d   = 1'b0;
      ovr_d    = ovr_q;
      if (count_en && disp_fall) begin
         line_d  = vblank ? '0 : line_q + LINE_W'(1);
         frame_d = vblank ? frame_q + FRAME_CNT_W'(1) : frame_q;
         tick_d  = vblank;
      end
      case (state_q)
         S_IDLE: begin
            state_d  = S_ACTIVE;
            vga_en_d = 1'b1;
         end
         S_ACTIVE: begin
            if (vblank && !bus.pause_i) begin
               state_d = S_UPDATE;
               req_d   = 1'b1;
            end
         end
         S_UPDATE: begin
            // next frame's display starting beats a same-cycle done
            if (disp_rise) begin
               ovr_d = 1'b1;
`ifndef VGA_OVERRUN_RETRY_EN
               req_d   = 1'b0;
               state_d = S_ACTIVE;
`endif
            end else if (bus.upd_done_i) begin
               req_d   = 1'b0;
               state_d = S_READY;
            end
         end
         S_READY: begin
            if (vs_fall) begin
               swap_d  = 1'b1;
               state_d = S_ACTIVE;
            end else if (disp_rise) begin
               // display resumed before the sync that should carry the swap
               ovr_d = 1'b1;
`ifndef VGA_OVERRUN_RETRY_EN
               state_d = S_ACTIVE;
`endif
            end
         end
      endcase
      // dropping the run request overrides everything and clears the frame history
      if (!bus.en_i) begin
         state_d  = S_IDLE;
         line_d   = '0;
         frame_d  = '0;
         vga_en_d = 1'b0;
         tick_d   = 1'b0;
         req_d    = 1'b0;
         swap_d   = 1'b0;
         ovr_d    = 1'b0;
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         line_q   <= '0;
         frame_q  <= '0;
         disp_q   <= 1'b0;
         vs_q     <= 1'b0;
         vga_en_q <= 1'b0;
         tick_q   <= 1'b0;
         req_q    <= 1'b0;
         swap_q   <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         line_q   <= line_d;
         frame_q  <= frame_d;
         disp_q   <= bus.disp_i;
         vs_q     <= bus.v_sync_i;
         vga_en_q <= vga_en_d;
         tick_q   <= tick_d;
         req_q    <= req_d;
         swap_q   <= swap_d;
         ovr_q    <= ovr_d;
      end
   end
   assign bus.vga_en_o     = vga_en_q;
   assign bus.frame_tick_o = tick_q;
   assign bus.upd_req_o    = req_q;
   assign bus.swap_o       = swap_q;
   assign bus.overrun_o    = ovr_q;
   assign bus.frame_cnt_o  = frame_q;
endmodule

// File: tb/tb_vga_frame_ctrl.sv
// tb_vga_frame_ctrl: self-checking bench for vga_frame_ctrl driven by a scaled-down VGA timing generator
module tb_vga_frame_ctrl;
   localparam int VD  = 8;
   localparam int LW  = 4;
   localparam int FCW = 4;
   localparam int HT  = 16;
   localparam int HD  = 10;
   localparam int VT  = 14;
   localparam int VSY = 2;
   localparam int VST = 4;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;
   vga_frame_ctrl_if #(.FRAME_CNT_W(FCW)) bus ();
   vga_frame_ctrl #(.V_DISP_LINES(VD), .LINE_W(LW), .FRAME_CNT_W(FCW)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );
   int checks = 0;
   int errors = 0;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #2;
   endtask
   task automatic wait_tick(input int budget, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < budget && !ok; k++) begin
         step();
         ok = bus.frame_tick_o;
      end
   endtask
   task automatic restart();
      bus.en_i = 1'b0;
      step();
      step();
      bus.en_i = 1'b1;
      step();
   endtask
   // timing generator: starts at line 0 whenever vga_en_o is seen high
   initial begin
      int h, v;
      h = 0;
      v = 0;
      bus.disp_i   = 1'b0;
      bus.v_sync_i = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (!bus.vga_en_o) begin
            h = 0;
            v = 0;
            bus.disp_i   = 1'b0;
            bus.v_sync_i = 1'b1;
         end else begin
            bus.disp_i   = (v >= VST) && (v < VST + VD) && (h < HD);
            bus.v_sync_i = !(v < VSY);
            h++;
            if (h == HT) begin
               h = 0;
               v = (v + 1) % VT;
            end
         end
      end
   end
   // reference model: frames are counted as total visible-line ends divided by VD
   bit m_on, m_req, m_pend, m_ovr, m_tick, m_swap, p_disp, p_vs;
   int m_falls;
   task automatic model_clear();
      m_on = 0; m_req = 0; m_pend = 0; m_ovr = 0; m_tick = 0; m_swap = 0;
      p_disp = 0; p_vs = 0; m_falls = 0;
   endtask
   task automatic model_step(input bit en, input bit pause, input bit done, input bit vs, input bit disp);
      bit fall, rise, vsf, was_req, was_pend;
      fall = p_disp && !disp;
      rise = !p_disp && disp;
      vsf  = p_vs && !vs;
      m_tick = 0;
      m_swap = 0;
      was_req  = m_req;
      was_pend = m_pend;
      if (!en) begin
         m_on = 0; m_req = 0; m_pend = 0; m_ovr = 0; m_falls = 0;
      end else if (!m_on) begin
         m_on = 1;
      end else begin
`ifdef VGA_OVERRUN_RETRY_EN
         if (was_req) begin
            if (rise) m_ovr = 1;
            else if (done) begin m_req = 0; m_pend = 1; end
         end else if (was_pend) begin
            if (vsf) begin m_swap = 1; m_pend = 0; end
            else if (rise) m_ovr = 1;
         end
         if (fall) begin
            m_falls++;
            if (m_falls % VD == 0) begin
               m_tick = 1;
               if (!was_req && !was_pend && !pause) m_req = 1;
            end
         end
`else
         if (was_req) begin
            if (rise) begin m_ovr = 1; m_req = 0; end
            else if (done) begin m_req = 0; m_pend = 1; end
         end else if (was_pend) begin
            if (vsf) begin m_swap = 1; m_pend = 0; end
            else if (rise) begin m_ovr = 1; m_pend = 0; end
         end else if (fall) begin
            m_falls++;
            if (m_falls % VD == 0) begin
               m_tick = 1;
               if (!pause) m_req = 1;
            end
         end
`endif
      end
      p_disp = disp;
      p_vs   = vs;
   endtask
   initial begin
      model_clear();
      forever begin
         @(posedge clk);
         if (rst) model_clear();
         else model_step(bus.en_i, bus.pause_i, bus.upd_done_i, bus.v_sync_i, bus.disp_i);
         @(negedge clk);
         if (rst) model_clear();
         chk("mon_vga_en", bus.vga_en_o, m_on);
         chk("mon_tick", bus.frame_tick_o, m_tick);
         chk("mon_req", bus.upd_req_o, m_req);
         chk("mon_swap", bus.swap_o, m_swap);
         chk("mon_ovr", bus.overrun_o, m_ovr);
         chk("mon_frame_cnt", bus.frame_cnt_o, (m_falls / VD) % (1 << FCW));
      end
   end
   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end
   typedef struct {
      bit pause;
      int dly;
      bit req;
      int swaps;
      bit ovr;
   } vec_t;
   initial begin
      vec_t tbl[6];
      bit ok, req_seen, prev, found;
      int swaps, ticks, rate;
      // done delays are cycles after the tick; vsync falls ~37 and display resumes ~101 cycles later
      tbl[0] = '{pause: 0, dly: 10,  req: 1, swaps: 1, ovr: 0};
      tbl[1] = '{pause: 1, dly: -1,  req: 0, swaps: 0, ovr: 0};
      tbl[2] = '{pause: 0, dly: -1,  req: 1, swaps: 0, ovr: 1};
      tbl[3] = '{pause: 0, dly: 60,  req: 1, swaps: 0, ovr: 1};
      tbl[4] = '{pause: 0, dly: 0,   req: 1, swaps: 1, ovr: 0};
      tbl[5] = '{pause: 0, dly: 150, req: 1, swaps: 0, ovr: 1};
      rst = 1'b1;
      bus.en_i = 1'b1;
      bus.pause_i = 1'b0;
      bus.upd_done_i = 1'b0;
      repeat (3) step();
      chk("rst_vga_en", bus.vga_en_o, 0);
      chk("rst_tick", bus.frame_tick_o, 0);
      chk("rst_req", bus.upd_req_o, 0);
      chk("rst_swap", bus.swap_o, 0);
      chk("rst_ovr", bus.overrun_o, 0);
      chk("rst_frame_cnt", bus.frame_cnt_o, 0);
      rst = 1'b0;
      step();
      chk("rel_vga_en", bus.vga_en_o, 1);
      chk("rel_frame_cnt", bus.frame_cnt_o, 0);
      for (int i = 0; i < 6; i++) begin
         restart();
         bus.pause_i = tbl[i].pause;
         wait_tick(600, ok);
         chk($sformatf("vec%0d_tick_seen", i), ok, 1);
         req_seen = bus.upd_req_o;
         swaps = 0;
         for (int c = 0; c < 140; c++) begin
            bus.upd_done_i = (c == tbl[i].dly);
            step();
            swaps += bus.swap_o;
         end
         bus.upd_done_i = 1'b0;
         chk($sformatf("vec%0d_req", i), req_seen, tbl[i].req);
         chk($sformatf("vec%0d_swaps", i), swaps, tbl[i].swaps);
         chk($sformatf("vec%0d_ovr", i), bus.overrun_o, tbl[i].ovr);
         chk($sformatf("vec%0d_frame_cnt", i), bus.frame_cnt_o, 1);
      end
      restart();
      bus.pause_i = 1'b1;
      ticks = 0;
      req_seen = 1'b0;
      for (int k = 0; k < 1000 && ticks < 3; k++) begin
         step();
         ticks += bus.frame_tick_o;
         req_seen |= bus.upd_req_o;
      end
      chk("pause_ticks", ticks, 3);
      chk("pause_req", req_seen, 0);
      chk("pause_frame_cnt", bus.frame_cnt_o, 3);
      bus.pause_i = 1'b0;
      restart();
      wait_tick(600, ok);
      chk("simul_tick_seen", ok, 1);
      found = 1'b0;
      for (int k = 0; k < 300 && !found; k++) begin
         prev = bus.disp_i;
         step();
         found = bus.disp_i && !prev;
      end
      chk("simul_rise_seen", found, 1);
      bus.upd_done_i = 1'b1;
      step();
      bus.upd_done_i = 1'b0;
      chk("simul_ovr", bus.overrun_o, 1);
      chk("simul_req", bus.upd_req_o, 0);
      chk("simul_swap", bus.swap_o, 0);
      wait_tick(600, ok);
      chk("drop_tick_seen", ok, 1);
      chk("drop_req_before", bus.upd_req_o, 1);
      bus.en_i = 1'b0;
      step();
      chk("drop_vga_en", bus.vga_en_o, 0);
      chk("drop_req", bus.upd_req_o, 0);
      chk("drop_ovr", bus.overrun_o, 0);
      chk("drop_frame_cnt", bus.frame_cnt_o, 0);
      bus.en_i = 1'b1;
      step();
      bus.pause_i = 1'b1;
      ticks = 0;
      for (int k = 0; k < 5000 && ticks < 17; k++) begin
         step();
         ticks += bus.frame_tick_o;
      end
      chk("wrap_ticks", ticks, 17);
      chk("wrap_frame_cnt", bus.frame_cnt_o, 1);
      for (int f = 0; f < 30; f++) begin
         case ($urandom_range(0, 3))
            0: rate = 1;
            1: rate = 8;
            2: rate = 64;
            default: rate = 1000;
         endcase
         bus.pause_i = ($urandom_range(0, 3) == 0);
         for (int c = 0; c < 224; c++) begin
            bus.upd_done_i = ($urandom_range(0, rate - 1) == 0);
            bus.en_i = ($urandom_range(0, 1499) != 0);
            step();
         end
      end
      bus.upd_done_i = 1'b0;
      step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/vga_frame_ctrl.md
Name: vga_frame_ctrl

Overview:
- Frame-level sequencer for the VGA driver. Owns the driver's enable and watches its v_sync/disp outputs.
- Opens a game-logic update window during vertical blanking, and arbitrates when the frame-buffer swap may occur.
- Sits between the top-level game FSM, the object-update logic and the VGA driver.

Parameters:
- V_DISP_LINES, 480, number of visible lines per frame (disp high-periods per frame).
- LINE_W, 10, line counter width; must hold V_DISP_LINES-1.
- FRAME_CNT_W, 16, frame counter width.

Ports:
- clk  input  1  pixel clock, shared with VGA driver.
- rst  input  1  asynchronous, active-high reset.
- en_i  input  1  run request from game FSM.
- pause_i  input  1  suppress update requests while high.
- v_sync_i  input  1  driver field sync, active low.
- disp_i  input  1  driver active-display flag.
- upd_done_i  input  1  update logic finished, pulse or level.
- vga_en_o  output  1  enable to VGA driver.
- frame_tick_o  output  1  one-cycle pulse at vblank entry.
- upd_req_o  output  1  level, update window open.
- swap_o  output  1  one-cycle pulse, swap frame buffers.
- overrun_o  output  1  sticky, update missed its window.
- frame_cnt_o  output  FRAME_CNT_W  count of vblank entries, wraps.

Behaviour:
- All outputs are registered. Reset drives every output to 0, state to IDLE, line_cnt to 0, disp_q to 0 and vs_q to 0.
- disp_q and vs_q sample disp_i and v_sync_i every cycle in all states. Edges are the current input versus the _q value, so there are no spurious edges on enable.
- States: IDLE, ACTIVE, UPDATE, READY.
- en_i=0 in any state: next cycle is IDLE; vga_en_o, upd_req_o, overrun_o, line_cnt and frame_cnt_o are all 0. This has priority over all other events.
- IDLE: en_i=1 → ACTIVE, vga_en_o=1 next cycle. The driver then starts at line 0.
- ACTIVE: each disp falling edge increments line_cnt.
- ACTIVE, disp falling edge with line_cnt==V_DISP_LINES-1, at that clock edge:
  - line_cnt←0, frame_cnt_o+1, frame_tick_o←1 for one cycle.
  - pause_i=0: →UPDATE, upd_req_o←1.
  - pause_i=1: stay ACTIVE, no request.
- UPDATE, upd_done_i=1 and no disp rising edge: upd_req_o←0, →READY.
- UPDATE, disp rising edge (next frame's active region begins), including when upd_done_i is high the same cycle: overrun_o←1, upd_req_o←0, no swap, →ACTIVE. Overrun wins.
- UPDATE, v_sync falling edge: no effect.
- READY, v_sync falling edge: swap_o←1 for one cycle, →ACTIVE.
- READY, disp rising edge without a preceding v_sync fall: protocol violation. overrun_o←1, no swap, →ACTIVE.
- upd_done_i is ignored outside UPDATE.
- pause_i is sampled only at vblank entry.
- Latency: disp falling edge at cycle N → frame_tick_o/upd_req_o high at N+1; v_sync falling edge at cycle M → swap_o high at M+1.
- overrun_o clears only on rst or en_i=0.
- frame_cnt_o wraps from all-ones to 0.

Optional Feature:
- Macro: VGA_OVERRUN_RETRY_EN.
- Defined:
  - On overrun, upd_req_o stays high and state stays UPDATE through the active display.
  - A later upd_done_i →READY, then swap at the next v_sync falling edge.
  - overrun_o is still set.
  - A vblank entry while in UPDATE/READY pulses frame_tick_o and increments frame_cnt_o only.
  - Line counting continues in UPDATE/READY while retrying.
- Undefined: behaviour exactly as above; the update is dropped.

Test Plan:
All scenarios use 640x480@60 driver timing: H_TOTAL 800, V_TOTAL 525, V_SYNC 2, V_START 35.
- Reset: rst=1 with en_i=1 → all outputs 0. Release rst → vga_en_o=1 one cycle later, frame_cnt_o=0.
- Normal frame: upd_done_i pulse 100 cycles after upd_req_o rises → upd_req_o=0 next cycle; swap_o is a single-cycle pulse one cycle after the v_sync_i fall; frame_cnt_o=1; overrun_o=0.
- Missed window: hold upd_done_i=0 → overrun_o=1 and upd_req_o=0 one cycle after the first disp_i rise of frame 2; swap_o never pulses.
- Pause: pause_i=1 over 3 frames → frame_tick_o pulses 3 times, upd_req_o stays 0, frame_cnt_o=3.
- Simultaneous: upd_done_i=1 on the same cycle as the disp_i rise → overrun_o=1, no swap_o. Drop en_i in UPDATE → IDLE next cycle, vga_en_o=0, upd_req_o=0, overrun_o=0, frame_cnt_o=0.
- With VGA_OVERRUN_RETRY_EN: withhold upd_done_i for 1 frame, then pulse it → overrun_o=1, upd_req_o stays high, swap_o pulses at the following v_sync_i fall.
